// File: rtl/tank_sprite_arbiter.sv
// Per-pixel tank sprite arbiter: hit test, fixed-priority pick, shared ROM addressing.
// Optional spawn-shield blinking is enabled by defining TANK_BLINK_EN.
module tank_sprite_arbiter #(
  parameter int N_TANKS     = 4,
  parameter int ROM_LATENCY = 1,
  parameter int BLINK_LOG2  = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   pix_valid,
  input  logic [9:0]             draw_x,
  input  logic [9:0]             draw_y,
  input  logic                   frame_start,
  input  logic [10*N_TANKS-1:0]  tank_x,
  input  logic [10*N_TANKS-1:0]  tank_y,
  input  logic [2*N_TANKS-1:0]   tank_dir,
  input  logic [N_TANKS-1:0]     tank_alive,
  input  logic [N_TANKS-1:0]     tank_shield,
  output logic [9:0]             rom_address,
  output logic [1:0]             rom_dir,
  output logic                   out_valid,
  output logic                   out_enemy,
  output logic [1:0]             out_tank_id,
  output logic [1:0]             out_dir
);

  logic [N_TANKS-1:0] hit;
  logic [N_TANKS-1:0] mask;

`ifdef TANK_BLINK_EN
  logic [BLINK_LOG2:0] frame_q;
  logic [BLINK_LOG2:0] frame_d;

  assign frame_d = frame_q + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_q <= '0;
    end else if (frame_start) begin
      frame_q <= frame_d;
    end
  end

  assign mask = frame_q[BLINK_LOG2] ? tank_shield : '0;
`else
  logic [BLINK_LOG2:0] unused_blink;

  assign unused_blink = {(BLINK_LOG2+1){^{frame_start, tank_shield}}};
  assign mask = '0;
`endif

  // 11-bit compare so tx+32 cannot wrap at the right screen edge
  always_comb begin
    hit = '0;
    for (int i = 0; i < N_TANKS; i++) begin
      hit[i] = tank_alive[i] && pix_valid && !mask[i]
        && ({1'b0, draw_x} >= {1'b0, tank_x[10*i +: 10]})
        && ({1'b0, draw_x} < ({1'b0, tank_x[10*i +: 10]} + 11'd32))
        && ({1'b0, draw_y} >= {1'b0, tank_y[10*i +: 10]})
        && ({1'b0, draw_y} < ({1'b0, tank_y[10*i +: 10]} + 11'd32));
    end
  end

  logic       any_d;
  logic [1:0] id_d;
  logic [1:0] dir_d;
  logic [4:0] dx_d;
  logic [4:0] dy_d;

  // descending scan so the lowest hitting index wins
  always_comb begin
    any_d = |hit;
    id_d  = '0;
    dir_d = '0;
    dx_d  = '0;
    dy_d  = '0;
    for (int i = N_TANKS - 1; i >= 0; i--) begin
      if (hit[i]) begin
        id_d  = 2'(i);
        dir_d = tank_dir[2*i +: 2];
        dx_d  = draw_x[4:0] - tank_x[10*i +: 5];
        dy_d  = draw_y[4:0] - tank_y[10*i +: 5];
      end
    end
  end

  logic [9:0] rom_address_q;
  logic [1:0] rom_dir_q;
  logic [5:0] sb1_q;
  logic [5:0] sb1_d;
  logic [5:0] sb_q [ROM_LATENCY];

  assign sb1_d = {any_d, (id_d != 2'd0), id_d, dir_d};

  always_ff @(posedge clk) begin
    if (reset) begin
      rom_address_q <= '0;
      rom_dir_q     <= '0;
      sb1_q         <= '0;
      for (int k = 0; k < ROM_LATENCY; k++) begin
        sb_q[k] <= '0;
      end
    end else begin
      rom_address_q <= {dy_d, dx_d};
      rom_dir_q     <= dir_d;
      sb1_q         <= sb1_d;
      sb_q[0]       <= sb1_q;
      for (int k = 1; k < ROM_LATENCY; k++) begin
        sb_q[k] <= sb_q[k-1];
      end
    end
  end

  assign rom_address = rom_address_q;
  assign rom_dir     = rom_dir_q;
  assign {out_valid, out_enemy, out_tank_id, out_dir} = sb_q[ROM_LATENCY-1];

endmodule

// File: doc/tank_sprite_arbiter.md
Name: tank_sprite_arbiter

Overview:
- Per-pixel scheduler that shares one 32x32 tank sprite ROM path (1024-entry, 2-bit index, synchronous read) among N tanks during VGA scanout.
- Hit-tests the current draw pixel against every live tank and selects one winner by fixed priority.
- Drives the shared ROM address and direction select; pipelines enemy/direction/id sideband so it lines up with ROM data at the palette stage.
- Sits between the VGA controller / game-state logic and the direction sprite ROMs plus friendly/enemy palettes.

Parameters:
- N_TANKS, 4, number of tanks; index 0 is the player (friendly), 1..N_TANKS-1 are enemies.
- ROM_LATENCY, 1, sprite ROM read latency in clocks (address registered to data valid).
- BLINK_LOG2, 3, blink half-period is 2^BLINK_LOG2 frames (used only with the optional feature).

Ports:
- clk  in  1  pixel clock.
- reset  in  1  synchronous, active-high.
- pix_valid  in  1  draw_x/draw_y is an active-video pixel this cycle.
- draw_x  in  10  current pixel column, 0..639.
- draw_y  in  10  current pixel row, 0..479.
- frame_start  in  1  one-cycle pulse at the start of each frame.
- tank_x  in  10*N_TANKS  packed top-left x per tank; tank i at [10i+9:10i].
- tank_y  in  10*N_TANKS  packed top-left y per tank.
- tank_dir  in  2*N_TANKS  packed facing: 0 up, 1 down, 2 left, 3 right.
- tank_alive  in  N_TANKS  tank participates in hit test.
- tank_shield  in  N_TANKS  spawn protection active; affects drawing only with BLINK_EN.
- rom_address  out  10  shared sprite ROM address, registered.
- rom_dir  out  2  selects which direction ROM output is used, registered alongside rom_address.
- out_valid  out  1  ROM data this cycle belongs to a tank pixel.
- out_enemy  out  1  palette select, 1 = enemy palette, 0 = friendly; aligned with ROM data.
- out_tank_id  out  2  winning tank index; aligned with ROM data.
- out_dir  out  2  winning direction; aligned with ROM data.

Behaviour:
- Stage 0, combinational: for each tank i, hit_i = tank_alive[i] && pix_valid && draw_x >= tx && draw_x < tx+32 && draw_y >= ty && draw_y < ty+32.
- Compare in 11 bits; tx+32 never wraps. Example: tx=620 covers x 620..651; only 620..639 are ever presented.
- Winner = lowest index with hit_i set, so the player is drawn over enemies and lower enemy indices over higher ones.
- Stage 1, registered at the next edge:
  - rom_address = {(draw_y-ty)[4:0], (draw_x-tx)[4:0]}, i.e. row*32+col of the winner.
  - rom_dir = winner's tank_dir.
  - hit1 = any hit; sideband latches winner id, dir and enemy = (id != 0).
  - With no hit, rom_address=0 and rom_dir=0 (ROM is still read; result ignored).
- Sideband pipeline: hit1/id/dir/enemy are delayed a further ROM_LATENCY registers and drive out_valid/out_tank_id/out_dir/out_enemy.
- Total latency is 1+ROM_LATENCY clocks from pixel presentation to out_* (2 at default). The pipeline is free-running, with no stalls.
- Outputs on a no-hit cycle: out_valid=0, out_enemy=0, out_tank_id=0, out_dir=0.
- Inputs change every cycle and are not held; tank position changes take effect on the first pixel presented after the change, even mid-frame.
- Reset: every pipeline register and output goes to 0 on the edge where reset=1. Any in-flight pixels are discarded, and out_valid stays 0 until 1+ROM_LATENCY clocks after reset deasserts.
- frame_start has no effect without BLINK_EN.

Optional Feature:
- Macro: TANK_BLINK_EN.
- When defined:
  - A BLINK_LOG2+1-bit frame counter increments on each frame_start and resets to 0.
  - While counter[BLINK_LOG2]=1, any tank with tank_shield[i]=1 is forced to hit_i=0. A lower-priority overlapping tank may then win that pixel.
  - frame_start and reset on the same edge: reset wins, counter=0.
- When undefined: no counter, tank_shield is ignored, and the hit test uses tank_alive only.

Test Plan:
- Player only, tank0 at (100,200) dir=2, pixel (105,203) -> two clocks later out_valid=1, out_enemy=0, out_tank_id=0, out_dir=2; rom_address=3*32+5=101 one clock after presentation.
- Overlap: tank0 at (100,100), tank2 at (110,100), both alive, pixel (115,105) -> out_tank_id=0, out_enemy=0. Kill tank0 -> out_tank_id=2, out_enemy=1, rom_address=5*32+5=165.
- Boundaries, tank1 at (50,60):
  - (81,91) hit, rom_address=1023.
  - (82,91) miss.
  - (50,92) miss.
  - (49,60) miss.
- Right edge: tank3 at (620,400), pixel (639,431) -> hit, rom_address=31*32+19=1011. pix_valid=0 at the same coordinates -> out_valid=0.
- Reset mid-stream: hitting pixels every cycle, assert reset one cycle -> all outputs 0 next edge; out_valid stays 0 for two clocks after deassert, then resumes.
- TANK_BLINK_EN, BLINK_LOG2=3, tank0 shielded over tank1, pixel inside both:
  - Frames 0-7: out_tank_id=0.
  - Frames 8-15: out_tank_id=1.
  - Frame 16: out_tank_id=0.
  - Without the macro: always out_tank_id=0.
